// File: rtl/fft_output_if.sv
// Memory read port and result stream of the FFT output drain.
// master = fft_output side, slave = memory/consumer side.
interface fft_output_if #(
  parameter int N         = 32,
  parameter int word_size = 16
);
  localparam int AW = $clog2(N);

  logic                   rd_en;
  logic [AW-1:0]          addr1;
  logic [AW-1:0]          addr2;
  logic [2*word_size-1:0] rd_data1;
  logic [2*word_size-1:0] rd_data2;
  logic [2*word_size-1:0] out1;
  logic [2*word_size-1:0] out2;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output rd_en, addr1, addr2, out1, out2, out_valid, out_last,
    input  rd_data1, rd_data2, out_ready
  );

  modport slave (
    input  rd_en, addr1, addr2, out1, out2, out_valid, out_last,
    output rd_data1, rd_data2, out_ready
  );
endinterface

// File: rtl/fft_output.sv
// FFT result drain: credit-limited paired reads, optional bit-reversed addressing,
// read-latency pipe into a small pair FIFO, scaled valid/ready output stream.

module fft_output_chk #(
  parameter int CW    = 2,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          push,
  input logic [CW-1:0] count
);
  // The issue credit must never let a returning read land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CW'(DEPTH))));
endmodule

module fft_output #(
  parameter int N           = 32,
  parameter int word_size   = 16,
  parameter int RD_LATENCY  = 1,
  parameter int BIT_REVERSE = 1,
  parameter int SCALE_SHIFT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         fft_done,
  output logic         busy,
  output logic         o_done,
  fft_output_if.master bus
);
  localparam int AW    = $clog2(N);
  localparam int W2    = 2 * word_size;
  localparam int DEPTH = RD_LATENCY + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam logic [AW-1:0] K_LAST   = AW'(N - 2);
  localparam logic [AW-1:0] ADDR_MSB = AW'(N / 2);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = {AW{1'b0}};
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  function automatic logic [word_size-1:0] scale_comp(input logic [word_size-1:0] c);
    logic signed [word_size-1:0] t;
    t = $signed(c) >>> SCALE_SHIFT;
    return t;
  endfunction

  function automatic logic [W2-1:0] scale_sample(input logic [W2-1:0] s);
    return {scale_comp(s[W2-1:word_size]), scale_comp(s[word_size-1:0])};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  state_t                 state_r, state_s;
  logic [AW-1:0]          k_r, addr1_r, addr2_r;
  logic                   rd_en_r, rd_last_r, busy_r, o_done_r;
  logic [RD_LATENCY-1:0]  pipe_vld_r, pipe_last_r;
  logic [W2-1:0]          fifo_d1_r [DEPTH];
  logic [W2-1:0]          fifo_d2_r [DEPTH];
  logic [DEPTH-1:0]       fifo_last_r;
  logic [PW-1:0]          wptr_r, rptr_r;
  logic [CW-1:0]          count_r, inflight_s;
  logic                   issue_s, push_s, pop_s, credit_s;
  logic [AW-1:0]          addr1_s, addr2_s;

  // Reads issued but not yet pushed: the rd_en stage plus every latency stage.
  always_comb begin
    inflight_s = {{(CW-1){1'b0}}, rd_en_r};
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + {{(CW-1){1'b0}}, pipe_vld_r[i]};
    end
  end

  // Issue credit, FIFO strobes and the address pair for the current k.
  always_comb begin
    credit_s = ({1'b0, count_r} + {1'b0, inflight_s}) < DEPTH_W;
    issue_s  = (state_r == S_READ) && en && credit_s;
    push_s   = pipe_vld_r[RD_LATENCY-1];
    pop_s    = (count_r != CW'(0)) && bus.out_ready;
    if (BIT_REVERSE != 0) begin
      addr1_s = bitrev(k_r);
      addr2_s = bitrev(k_r) | ADDR_MSB;
    end else begin
      addr1_s = k_r;
      addr2_s = k_r | AW'(1);
    end
  end

  // Next-state logic; DRAIN finishes on the cycle the last pair leaves.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (en && fft_done) state_s = S_READ; else state_s = S_IDLE;
      S_READ:  if (issue_s && (k_r == K_LAST)) state_s = S_DRAIN; else state_s = S_READ;
      S_DRAIN: begin
        if ((inflight_s == CW'(0)) &&
            ((count_r == CW'(0)) || ((count_r == CW'(1)) && pop_s))) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, status flags and the registered read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      k_r       <= {AW{1'b0}};
      addr1_r   <= {AW{1'b0}};
      addr2_r   <= {AW{1'b0}};
      rd_en_r   <= 1'b0;
      rd_last_r <= 1'b0;
      busy_r    <= 1'b0;
      o_done_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s == S_READ) || (state_s == S_DRAIN);
      o_done_r <= (state_s == S_DONE);
      rd_en_r  <= issue_s;
      if (state_r == S_IDLE) begin
        k_r <= {AW{1'b0}};
      end else if (issue_s) begin
        k_r       <= k_r + AW'(2);
        addr1_r   <= addr1_s;
        addr2_r   <= addr2_s;
        rd_last_r <= (k_r == K_LAST);
      end
    end
  end

  // Valid/last shift register matching the memory read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld_r  <= {RD_LATENCY{1'b0}};
      pipe_last_r <= {RD_LATENCY{1'b0}};
    end else begin
      pipe_vld_r[0]  <= rd_en_r;
      pipe_last_r[0] <= rd_last_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_last_r[i] <= pipe_last_r[i-1];
      end
    end
  end

  // Pair FIFO; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r      <= {PW{1'b0}};
      rptr_r      <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      fifo_last_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_d1_r[i] <= {W2{1'b0}};
        fifo_d2_r[i] <= {W2{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_d1_r[wptr_r]   <= bus.rd_data1;
        fifo_d2_r[wptr_r]   <= bus.rd_data2;
        fifo_last_r[wptr_r] <= pipe_last_r[RD_LATENCY-1];
        wptr_r              <= ptr_inc(wptr_r);
      end
      if (pop_s) rptr_r <= ptr_inc(rptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.rd_en     = rd_en_r;
  assign bus.addr1     = addr1_r;
  assign bus.addr2     = addr2_r;
  assign bus.out_valid = (count_r != CW'(0));
  assign bus.out_last  = (count_r != CW'(0)) && fifo_last_r[rptr_r];
  assign bus.out1      = scale_sample(fifo_d1_r[rptr_r]);
  assign bus.out2      = scale_sample(fifo_d2_r[rptr_r]);
  assign busy          = busy_r;
  assign o_done        = o_done_r;

  fft_output_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .count (count_r)
  );
endmodule

// File: tb/tb_fft_output.sv
// Scoreboard bench for fft_output: random memory contents, random backpressure and
// enable, expected pairs derived from index order and floor-division scaling.
module tb_fft_output;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int L  = 3;
  localparam int BR = 1;
  localparam int S  = 2;
  localparam int AW = 4;
  localparam int DEPTH = L + 1;

  typedef struct packed { logic [31:0] o1; logic [31:0] o2; logic last; } exp_t;
  typedef struct packed { logic [AW-1:0] a1; logic [AW-1:0] a2; } adr_t;

  logic clk = 1'b0;
  logic reset, en, fft_done, busy, o_done;
  int total = 0;
  int bad = 0;
  int issued_cnt = 0;
  int done_cnt = 0;
  int iss_base, done_base;
  exp_t exp_q[$];
  adr_t addr_q[$];

  fft_output_if #(.N(N), .word_size(W)) bus ();

  fft_output #(.N(N), .word_size(W), .RD_LATENCY(L), .BIT_REVERSE(BR), .SCALE_SHIFT(S)) dut (
    .clk(clk), .reset(reset), .en(en), .fft_done(fft_done),
    .busy(busy), .o_done(o_done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory model: data appears L cycles after rd_en, junk otherwise.
  logic [31:0] mem [N];
  logic [AW-1:0] pa1 [L];
  logic [AW-1:0] pa2 [L];
  logic [L-1:0] pv;
  logic [31:0] junk;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv <= {pv[L-2:0], bus.rd_en};
      pa1[0] <= bus.addr1;
      pa2[0] <= bus.addr2;
      for (int i = 1; i < L; i++) begin
        pa1[i] <= pa1[i-1];
        pa2[i] <= pa2[i-1];
      end
      junk <= $urandom;
    end
  end
  assign bus.rd_data1 = pv[L-1] ? mem[pa1[L-1]] : junk;
  assign bus.rd_data2 = pv[L-1] ? mem[pa2[L-1]] : ~junk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int fdiv(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [31:0] ref_scale(input logic [31:0] s);
    int re, im, d;
    logic [31:0] r;
    d  = 1 << S;
    re = int'($signed(s[31:16]));
    im = int'($signed(s[15:0]));
    r[31:16] = 16'(fdiv(re, d));
    r[15:0]  = 16'(fdiv(im, d));
    return r;
  endfunction

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) if ((v & (1 << b)) != 0) r |= 1 << (AW - 1 - b);
    return r;
  endfunction

  // Monitor: address order, output pairs, held data under stall, done pulse.
  logic hold_pend = 1'b0;
  logic prev_last = 1'b0;
  logic [63:0] held;
  always @(negedge clk) begin
    if (reset) begin
      hold_pend <= 1'b0;
      prev_last <= 1'b0;
    end else begin
      if (bus.rd_en) begin
        issued_cnt <= issued_cnt + 1;
        chk("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          chk("addr_pair", {bus.addr1, bus.addr2}, {addr_q[0].a1, addr_q[0].a2});
          void'(addr_q.pop_front());
        end
      end
      if (hold_pend) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", {bus.out1, bus.out2}, held);
      end
      hold_pend <= bus.out_valid && !bus.out_ready;
      held <= {bus.out1, bus.out2};
      if (bus.out_valid && bus.out_ready) begin
        chk("pair_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("pair", {bus.out1, bus.out2}, {exp_q[0].o1, exp_q[0].o2});
          chk("last", bus.out_last, exp_q[0].last);
          void'(exp_q.pop_front());
        end
      end
      if (o_done || prev_last) chk("o_done", o_done, prev_last);
      prev_last <= bus.out_valid && bus.out_ready && bus.out_last;
      if (o_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic start_run();
    for (int k = 0; k < N; k += 2) begin
      int a1 = (BR != 0) ? brev(k) : k;
      int a2 = (BR != 0) ? brev(k + 1) : k + 1;
      addr_q.push_back('{AW'(a1), AW'(a2)});
      exp_q.push_back('{ref_scale(mem[a1]), ref_scale(mem[a2]), (k == N - 2)});
    end
    done_base = done_cnt;
    iss_base = issued_cnt;
    @(posedge clk); #1;
    fft_done = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    fft_done = 1'b0;
  endtask

  task automatic fill_mem(input bit special);
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    if (special) begin
      mem[5] = 32'h8000_0004;
      mem[3] = 32'h7FFF_FFFD;
    end
  endtask

  // mode 0: free-running; 1: random en/ready + stray fft_done; 2: stall; 3: en gap
  task automatic do_run(input int mode, input bit special);
    int c = 0;
    int c_stall = 0;
    bit finished = 1'b0;
    bit seen_valid = 1'b0;
    bit stall_done = 1'b0;
    fill_mem(special);
    start_run();
    while (!finished && c < 2000) begin
      @(posedge clk); #1;
      c++;
      case (mode)
        0: begin
          if (c == 1) chk("busy_run", busy, 1);
          if (c == L + 1) chk("lat_before", bus.out_valid, 0);
          if (c == L + 2) chk("lat_first", bus.out_valid, 1);
        end
        1: begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          en = ($urandom_range(0, 4) != 0);
          fft_done = (c == 4);
        end
        2: begin
          if (!seen_valid && bus.out_valid) begin
            seen_valid = 1'b1;
            bus.out_ready = 1'b0;
            c_stall = c;
          end else if (seen_valid && !stall_done && c == c_stall + 10) begin
            chk("stall_issues", issued_cnt - iss_base, DEPTH);
            bus.out_ready = 1'b1;
            stall_done = 1'b1;
          end
        end
        default: begin
          if (c == 2) en = 1'b0;
          if (c >= 3 && c <= 7) chk("en_low_rd_en", bus.rd_en, 0);
          if (c == 7) en = 1'b1;
        end
      endcase
      finished = (done_cnt != done_base);
    end
    chk("run_finished", finished, 1);
    en = 1'b1;
    fft_done = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", done_cnt - done_base, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("addr_drained", addr_q.size(), 0);
    chk("busy_after", busy, 0);
  endtask

  task automatic reset_midrun();
    int c = 0;
    fill_mem(1'b0);
    start_run();
    while (!((issued_cnt - iss_base) >= 1 && bus.rd_en) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("inflight_reached", bus.rd_en, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_ctrl", {bus.rd_en, bus.addr1, bus.addr2, bus.out_valid, bus.out_last, busy, o_done}, 0);
    chk("rst_mid_data", {bus.out1, bus.out2}, 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    fft_done = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {bus.rd_en, bus.addr1, bus.addr2, bus.out_valid, bus.out_last, busy, o_done}, 0);
    chk("rst_data", {bus.out1, bus.out2}, 0);
    reset = 1'b0;
    do_run(0, 1'b1);
    do_run(2, 1'b0);
    do_run(3, 1'b0);
    for (int r = 0; r < 3; r++) do_run(1, 1'b0);
    reset_midrun();
    do_run(0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
